// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle between NumInputs packet requesters and one shared output.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding environment: it drives the requesters and the downstream ready.
interface stream_rr_arbiter_if #(
   parameter int NumInputs = 4,
   parameter int DataBits  = 16,
   parameter int SelBits   = 2
);
   logic [NumInputs-1:0]          in_valid;
   logic [NumInputs-1:0]          in_ready;
   logic [NumInputs*DataBits-1:0] in_data;
   logic [NumInputs-1:0]          in_last;
   logic                          out_valid;
   logic                          out_ready;
   logic [DataBits-1:0]           out_data;
   logic                          out_last;
   logic [SelBits-1:0]            out_sel;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_sel
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_sel
   );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin packet arbiter: several packet streams share one output.
// A grant is held from the first beat of a packet until its last beat
// transfers, so packets never interleave. Each packet costs one arbitration
// bubble in IDLE. Within a packet, data passes straight through.
module stream_rr_arbiter #(
   parameter int NumInputs = 4,
   parameter int DataBits  = 16,
   parameter int SelBits   = 2
) (
   input  logic               clk,
   input  logic               rst,
   stream_rr_arbiter_if.slave bus
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Pointer reset value makes input 0 the first choice after reset.
   localparam logic [SelBits-1:0] PtrRst = SelBits'(NumInputs - 1);

   state_t             state_q, state_d;
   logic [SelBits-1:0] grant_q, grant_d;
   logic [SelBits-1:0] ptr_q, ptr_d;

   logic [DataBits-1:0]  data_arr [NumInputs];
   logic                 out_valid_c;
   logic                 out_last_c;
   logic [DataBits-1:0]  out_data_c;
   logic [NumInputs-1:0] in_ready_c;
   logic                 xfer_last;

   // The first requester found when searching ptr+1, ptr+2, ... (wrapping)
   // wins. The loop runs from the farthest candidate to the nearest one, so
   // the nearest requester is written last and takes priority. The input
   // just served (ptr itself) therefore comes last.
   function automatic logic [SelBits-1:0] rr_pick(
      input logic [NumInputs-1:0] req,
      input logic [SelBits-1:0]   ptr
   );
      logic [SelBits-1:0] pick;
      logic [SelBits-1:0] idx;
      pick = ptr;
      for (int k = NumInputs; k >= 1; k--) begin
         idx = SelBits'((int'(ptr) + k) % NumInputs);
         if (req[idx]) begin
            pick = idx;
         end
      end
      return pick;
   endfunction

   for (genvar g = 0; g < NumInputs; g++) begin : g_unpack
      assign data_arr[g] = bus.in_data[g*DataBits +: DataBits];
   end

   // Output mux follows the registered grant. Handshakes open only while locked.
   // in_ready depends only on state and out_ready, never on in_valid.
   always_comb begin
      out_valid_c = 1'b0;
      in_ready_c  = '0;
      out_data_c  = data_arr[grant_q];
      out_last_c  = bus.in_last[grant_q];
      if (state_q == ST_LOCKED) begin
         out_valid_c         = bus.in_valid[grant_q];
         in_ready_c[grant_q] = bus.out_ready;
      end
   end

   assign xfer_last = out_valid_c & bus.out_ready & out_last_c;

   // Next state: arbitrate in IDLE, and release the grant after the last beat transfers.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|bus.in_valid) begin
               grant_d = rr_pick(bus.in_valid, ptr_q);
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (xfer_last) begin
               ptr_d   = grant_q;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers. A reset abandons any packet in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= PtrRst;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = out_data_c;
   assign bus.out_last  = out_last_c;
   assign bus.out_sel   = grant_q;
   assign bus.in_ready  = in_ready_c;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: per-input packet sources, a ready-pattern
// queue, a spec-level arbitration model checked every cycle, a per-input
// scoreboard, and directed timing expectations for each scenario.
module tb_stream_rr_arbiter;
   localparam int N  = 4;
   localparam int DB = 16;
   localparam int SB = 2;

   typedef struct packed {
      logic [7:0]  gap;
      logic        last;
      logic [15:0] data;
   } beat_t;

   typedef struct {
      int          cyc;
      int          sel;
      logic [15:0] data;
      logic        last;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [N-1:0]    drv_valid = '0;
   logic [N*DB-1:0] drv_data  = '0;
   logic [N-1:0]    drv_last  = '0;
   logic            drv_ready = 1'b1;

   stream_rr_arbiter_if #(.NumInputs(N), .DataBits(DB), .SelBits(SB)) bus ();

   assign bus.in_valid  = drv_valid;
   assign bus.in_data   = drv_data;
   assign bus.in_last   = drv_last;
   assign bus.out_ready = drv_ready;

   stream_rr_arbiter #(.NumInputs(N), .DataBits(DB), .SelBits(SB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   beat_t       src_q [N][$];
   logic [16:0] exp_q [N][$];
   rec_t        log_q [$];
   bit          rdy_q [$];
   logic [N-1:0] acc = '0;

   // Model state: owner -1 means no packet is granted.
   int m_owner = -1;
   int m_ptr   = N - 1;
   bit prev_open = 1'b0;
   int prev_sel  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_beat(input int i, input logic [15:0] d, input logic l, input int gap);
      beat_t b;
      b.gap  = 8'(gap);
      b.last = l;
      b.data = d;
      src_q[i].push_back(b);
      exp_q[i].push_back({l, d});
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Sources: pop accepted beats, apply gaps, present heads; apply ready pattern.
   always @(posedge clk) begin
      beat_t h;
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      if (rdy_q.size() > 0) drv_ready = rdy_q.pop_front();
      else drv_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         drv_valid[i] = 1'b0;
         drv_last[i]  = 1'b0;
         drv_data[i*DB +: DB] = '0;
         if (src_q[i].size() > 0) begin
            h = src_q[i][0];
            if (h.gap != 0) begin
               h.gap = h.gap - 8'd1;
               src_q[i][0] = h;
            end else begin
               drv_valid[i] = 1'b1;
               drv_last[i]  = h.last;
               drv_data[i*DB +: DB] = h.data;
            end
         end
      end
   end

   // Compare process: model expectations, scoreboard, contiguity, then model update.
   always @(negedge clk) begin
      logic [N-1:0]  exp_rdy;
      logic          exp_ov;
      logic [SB-1:0] ow;
      logic [SB-1:0] ix;
      bit            found;
      rec_t          r;
      logic [16:0]   e;
      acc = bus.in_valid & bus.in_ready;
      if (cyc > 0) begin
         exp_ov  = 1'b0;
         exp_rdy = '0;
         ow      = SB'(m_owner < 0 ? 0 : m_owner);
         if (m_owner >= 0) begin
            exp_ov = bus.in_valid[ow];
            exp_rdy[ow] = bus.out_ready;
         end
         check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
         check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
         if (exp_ov) begin
            check("out_sel", 64'(bus.out_sel), 64'(m_owner));
            check("out_data", 64'(bus.out_data), 64'(bus.in_data[ow*DB +: DB]));
            check("out_last", 64'(bus.out_last), 64'(bus.in_last[ow]));
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            r.cyc  = cyc;
            r.sel  = int'(bus.out_sel);
            r.data = bus.out_data;
            r.last = bus.out_last;
            log_q.push_back(r);
            if (exp_q[r.sel].size() == 0) begin
               check("sb_extra_beat", 64'(r.sel), 64'hFF);
            end else begin
               e = exp_q[r.sel].pop_front();
               check("sb_beat", 64'({r.last, r.data}), 64'(e));
            end
            if (prev_open) check("contiguous_sel", 64'(r.sel), 64'(prev_sel));
            prev_open = !r.last;
            prev_sel  = r.sel;
         end
         if (rst) begin
            m_owner   = -1;
            m_ptr     = N - 1;
            prev_open = 1'b0;
         end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               ix = SB'((m_ptr + k) % N);
               if (!found && bus.in_valid[ix]) begin
                  found   = 1'b1;
                  m_owner = int'(ix);
               end
            end
         end else if (exp_ov && bus.out_ready && bus.in_last[ow]) begin
            m_ptr   = m_owner;
            m_owner = -1;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      while (!done && n < max) begin
         @(negedge clk);
         #1;
         n++;
         done = (m_owner < 0) && !bus.out_valid;
         for (int i = 0; i < N; i++) if (src_q[i].size() != 0) done = 1'b0;
      end
      check("drain_timeout", 64'(done), 64'd1);
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic check_rec(input string name, input int idx, input int ecyc, input int esel,
                            input logic [15:0] edata, input logic elast);
      if (log_q.size() > idx) begin
         check({name, "_cyc"}, 64'(log_q[idx].cyc), 64'(ecyc));
         check({name, "_sel"}, 64'(log_q[idx].sel), 64'(esel));
         check({name, "_data"}, 64'(log_q[idx].data), 64'(edata));
         check({name, "_last"}, 64'(log_q[idx].last), 64'(elast));
      end else begin
         check({name, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int base;
      int total;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
      // Reset state
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_sel", 64'(bus.out_sel), 64'd0);

      // 1: single 3-beat packet on input 0, one bubble then three beats
      base = log_q.size();
      k = cyc;
      push_beat(0, 16'hA1, 1'b0, 0);
      push_beat(0, 16'hA2, 1'b0, 0);
      push_beat(0, 16'hA3, 1'b1, 0);
      wait_done(50);
      check("t1_count", 64'(log_q.size() - base), 64'd3);
      check_rec("t1_b0", base + 0, k + 2, 0, 16'hA1, 1'b0);
      check_rec("t1_b1", base + 1, k + 3, 0, 16'hA2, 1'b0);
      check_rec("t1_b2", base + 2, k + 4, 0, 16'hA3, 1'b1);

      // 2: all inputs continuously requesting 2-beat packets
      do_reset();
      @(negedge clk);
      #1;
      base = log_q.size();
      k = cyc;
      for (int pk = 0; pk < 3; pk++) begin
         for (int i = 0; i < N; i++) begin
            push_beat(i, 16'(i * 256 + pk * 16), 1'b0, 0);
            push_beat(i, 16'(i * 256 + pk * 16 + 1), 1'b1, 0);
         end
      end
      wait_done(200);
      check("t2_count", 64'(log_q.size() - base), 64'd24);
      check("t2_first_cyc", 64'(log_q.size() > base ? log_q[base].cyc : -1), 64'(k + 2));
      for (int j = 0; j < 24; j++) begin
         if (log_q.size() > base + j) begin
            check("t2_sel", 64'(log_q[base+j].sel), 64'((j / 2) % N));
            check("t2_data", 64'(log_q[base+j].data),
                  64'(((j / 2) % N) * 256 + ((j / 2) / N) * 16 + (j % 2)));
            if (j > 0)
               check("t2_gap", 64'(log_q[base+j].cyc - log_q[base+j-1].cyc),
                     64'((j % 2 == 0) ? 2 : 1));
         end
      end

      // 3: granted input 2 stalls 3 cycles mid-packet while input 1 waits
      do_reset();
      @(negedge clk);
      #1;
      base = log_q.size();
      k = cyc;
      push_beat(2, 16'hC1, 1'b0, 0);
      push_beat(2, 16'hC2, 1'b0, 3);
      push_beat(2, 16'hC3, 1'b1, 0);
      push_beat(1, 16'hB1, 1'b1, 2);
      repeat (4) @(negedge clk);
      #1;
      check("t3_stall_valid", 64'(bus.out_valid), 64'd0);
      check("t3_stall_sel", 64'(bus.out_sel), 64'd2);
      check("t3_in1_waits", 64'(bus.in_ready[1]), 64'd0);
      wait_done(50);
      check_rec("t3_c1", base + 0, k + 2, 2, 16'hC1, 1'b0);
      check_rec("t3_c2", base + 1, k + 6, 2, 16'hC2, 1'b0);
      check_rec("t3_c3", base + 2, k + 7, 2, 16'hC3, 1'b1);
      check_rec("t3_b1", base + 3, k + 9, 1, 16'hB1, 1'b1);

      // 4: out_ready 1,0,0,1 mid-packet; input 1 request is ignored meanwhile
      do_reset();
      @(negedge clk);
      #1;
      base = log_q.size();
      k = cyc;
      push_beat(0, 16'hD1, 1'b0, 0);
      push_beat(0, 16'hD2, 1'b0, 0);
      push_beat(0, 16'hD3, 1'b0, 0);
      push_beat(0, 16'hD4, 1'b1, 0);
      push_beat(1, 16'hE0, 1'b1, 1);
      rdy_q.push_back(1'b1);
      rdy_q.push_back(1'b1);
      rdy_q.push_back(1'b1);
      rdy_q.push_back(1'b0);
      rdy_q.push_back(1'b0);
      rdy_q.push_back(1'b1);
      repeat (4) @(negedge clk);
      #1;
      check("t4_hold_valid", 64'(bus.out_valid), 64'd1);
      check("t4_hold_data", 64'(bus.out_data), 64'hD3);
      check("t4_hold_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      #1;
      check("t4_hold_data2", 64'(bus.out_data), 64'hD3);
      @(negedge clk);
      #1;
      check("t4_resume_ready", 64'(bus.in_ready), 64'd1);
      wait_done(50);
      check_rec("t4_d1", base + 0, k + 2, 0, 16'hD1, 1'b0);
      check_rec("t4_d2", base + 1, k + 3, 0, 16'hD2, 1'b0);
      check_rec("t4_d3", base + 2, k + 6, 0, 16'hD3, 1'b0);
      check_rec("t4_d4", base + 3, k + 7, 0, 16'hD4, 1'b1);
      check_rec("t4_e0", base + 4, k + 9, 1, 16'hE0, 1'b1);

      // 5: reset on beat 2 of a 4-beat packet from input 3; input 0 wins next
      do_reset();
      @(negedge clk);
      #1;
      base = log_q.size();
      k = cyc;
      push_beat(3, 16'h31, 1'b0, 0);
      push_beat(3, 16'h32, 1'b0, 0);
      push_beat(3, 16'h33, 1'b0, 0);
      push_beat(3, 16'h34, 1'b1, 0);
      push_beat(0, 16'hF1, 1'b1, 2);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
      check("t5_post_rst_valid", 64'(bus.out_valid), 64'd0);
      check("t5_post_rst_ready", 64'(bus.in_ready), 64'd0);
      check("t5_post_rst_sel", 64'(bus.out_sel), 64'd0);
      wait_done(50);
      check_rec("t5_e1", base + 0, k + 2, 3, 16'h31, 1'b0);
      check_rec("t5_e2", base + 1, k + 3, 3, 16'h32, 1'b0);
      check_rec("t5_f1", base + 2, k + 5, 0, 16'hF1, 1'b1);
      check_rec("t5_e3", base + 3, k + 7, 3, 16'h33, 1'b0);
      check_rec("t5_e4", base + 4, k + 8, 3, 16'h34, 1'b1);

      // 6: random packets, gaps and backpressure on all inputs
      do_reset();
      @(negedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         for (int pk = 0; pk < 15; pk++) begin
            int len;
            len = int'($urandom_range(1, 4));
            for (int b = 0; b < len; b++)
               push_beat(i, 16'($urandom), (b == len - 1), int'($urandom_range(0, 3)));
         end
      end
      for (int c = 0; c < 3000; c++) rdy_q.push_back($urandom_range(0, 3) != 0);
      wait_done(20000);
      rdy_q.delete();

      total = 0;
      for (int i = 0; i < N; i++) total += exp_q[i].size();
      check("sb_beats_outstanding", 64'(total), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
